// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: widths, tag-width helper and result entry type
// shared by the round-robin multiplier scheduler files.
package mult_sched_pkg;

  localparam int A_W       = 25;
  localparam int B_W       = 18;
  localparam int P_W       = 43;
  localparam int BUF_DEPTH = 2;
  localparam int ID_MAX_W  = 3;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [P_W-1:0]      p;
    logic [ID_MAX_W-1:0] id;
  } res_entry_t;

endpackage

// File: rtl/mult_sched_rr.sv
// mult_sched_rr: round-robin pointer and one-hot grant.
// The search starts at ptr; ptr moves past each granted requester.
module mult_sched_rr
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  output logic [NREQ-1:0]         gnt,
  output logic [id_w(NREQ)-1:0]   idx
);

  localparam int IDW = id_w(NREQ);
  localparam logic [IDW:0]   N_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ-1);

  logic [IDW-1:0] ptr;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;
  logic           found;

  // first pending requester at or after ptr, wrapping at NREQ
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= N_W)
        sum = sum - N_W;
      cand = sum[IDW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  // one-hot grant only when the caller has a free slot
  always_comb begin
    gnt = '0;
    if (en && found)
      gnt[idx] = 1'b1;
  end

  // advance past the granted requester, hold otherwise
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      ptr <= '0;
    else if (en && found)
      ptr <= (idx == LAST) ? '0 : idx + IDW'(1);
  end

endmodule

// File: rtl/mult_sched.sv
// mult_sched: shares one 25x18 DSP slice among NREQ requesters.
// Optional counters STAT_ISSUE/STAT_STALL under MULT_SCHED_STATS_EN.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MREG = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [NREQ*A_W-1:0]   REQ_A,
  input  logic [NREQ*B_W-1:0]   REQ_B,
  output logic [A_W-1:0]        MULT_A,
  output logic [B_W-1:0]        MULT_B,
  output logic                  MULT_CEM,
  output logic                  MULT_RSTM,
  input  logic [P_W-1:0]        MULT_PP1,
  input  logic [P_W-1:0]        MULT_PP2,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [P_W-1:0]        RES_P,
  output logic [id_w(NREQ)-1:0] RES_ID
`ifdef MULT_SCHED_STATS_EN
  ,
  output logic [15:0]           STAT_ISSUE,
  output logic [15:0]           STAT_STALL
`endif
);

  localparam int IDW = id_w(NREQ);

  logic [1:0]     occ;
  logic           infl;
  logic           pop;
  logic [2:0]     need;
  logic           credit;
  logic           rstm;
  logic           issue;
  logic [IDW-1:0] gid;
  logic           cap_v;
  logic [IDW-1:0] cap_id;
  logic           wi;
  res_entry_t     wr_e;
  res_entry_t     rbuf [BUF_DEPTH];
  logic           unused_id;

  assign pop    = RES_VALID & RES_READY;
  assign need   = 3'(occ) + 3'(infl) - 3'(pop);
  assign credit = need < 3'(BUF_DEPTH);

  // the slice is in reset on the first cycle, so nothing issues then
  mult_sched_rr #(.NREQ(NREQ)) u_rr (
    .CLK  (CLK),
    .RSTN (RSTN),
    .req  (REQ_VALID),
    .en   (credit & ~rstm),
    .gnt  (REQ_READY),
    .idx  (gid)
  );

  assign issue     = |REQ_READY;
  assign MULT_CEM  = issue;
  assign MULT_RSTM = rstm;

  // route the granted requester's operands onto the slice
  always_comb begin
    MULT_A = '0;
    MULT_B = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (REQ_READY[i]) begin
        MULT_A = REQ_A[i*A_W +: A_W];
        MULT_B = REQ_B[i*B_W +: B_W];
      end
    end
  end

  // slice reset flag: high in reset and for the first edge after it
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      rstm <= 1'b1;
    else
      rstm <= 1'b0;
  end

  generate
    if (MREG != 0) begin : g_mreg
      logic           v_q;
      logic [IDW-1:0] id_q;

      // carry issue strobe and tag alongside the slice M register
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          v_q  <= 1'b0;
          id_q <= '0;
        end else begin
          v_q  <= issue;
          id_q <= gid;
        end
      end

      assign cap_v  = v_q;
      assign cap_id = id_q;
      assign infl   = v_q;
    end else begin : g_comb
      assign cap_v  = issue;
      assign cap_id = gid;
      assign infl   = 1'b0;
    end
  endgenerate

  assign wr_e.p  = MULT_PP1 + MULT_PP2;
  assign wr_e.id = ID_MAX_W'(cap_id);

  // write slot 1 only when one entry stays after this cycle's pop
  assign wi = pop ? (occ == 2'd2) : (occ == 2'd1);

  // head shifts on pop; a new result lands at the first free slot
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < BUF_DEPTH; i++)
        rbuf[i] <= '0;
      occ <= '0;
    end else begin
      if (pop)
        rbuf[0] <= rbuf[1];
      if (cap_v)
        rbuf[wi] <= wr_e;
      occ <= occ + 2'(cap_v) - 2'(pop);
    end
  end

  assign RES_VALID = (occ != 2'd0);
  assign RES_P     = rbuf[0].p;
  assign RES_ID    = rbuf[0].id[IDW-1:0];
  assign unused_id = ^rbuf[0].id;

`ifdef MULT_SCHED_STATS_EN
  logic stall;

  assign stall = (|REQ_VALID) && !credit;

  // saturating issue and no-credit counters
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      STAT_ISSUE <= '0;
      STAT_STALL <= '0;
    end else begin
      if (issue && STAT_ISSUE != 16'hFFFF)
        STAT_ISSUE <= STAT_ISSUE + 16'd1;
      if (stall && STAT_STALL != 16'hFFFF)
        STAT_STALL <= STAT_STALL + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed checks of the multiplier scheduler with
// behavioural DSP slices for an MREG=1 and an MREG=0 instance.
module tb_mult_sched;

  localparam int N = 4;
  localparam logic [42:0] PMASK = 43'h2AAAAAAAAAA;

  logic CLK = 1'b0;
  logic RSTN;
  always #5 CLK = ~CLK;

  logic [N-1:0]    req_valid;
  logic [N*25-1:0] req_a;
  logic [N*18-1:0] req_b;
  logic            res_ready;

  logic [N-1:0] rdy1, rdy0;
  logic [24:0]  ma1, ma0;
  logic [17:0]  mb1, mb0;
  logic         cem1, cem0, rstm1, rstm0;
  logic [42:0]  pp1_1, pp2_1, pp1_0, pp2_0, p1, p0;
  logic         rv1, rv0;
  logic [1:0]   id1, id0;
  logic [42:0]  m1_q, prod0;
`ifdef MULT_SCHED_STATS_EN
  logic [15:0]  si1, ss1, si0, ss0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  longint cp [4] = '{21, -55, -26, -1000000};

  function automatic logic [42:0] mul(input logic [24:0] a,
                                      input logic [17:0] b);
    logic signed [42:0] ae, be;
    ae = 43'($signed(a));
    be = 43'($signed(b));
    return ae * be;
  endfunction

  function automatic logic [63:0] p43(input longint v);
    logic [63:0] t;
    t = v;
    return {21'd0, t[42:0]};
  endfunction

  always @(posedge CLK) begin
    if (rstm1)
      m1_q <= '0;
    else if (cem1)
      m1_q <= mul(ma1, mb1);
  end
  assign pp2_1 = m1_q & PMASK;
  assign pp1_1 = m1_q - pp2_1;

  assign prod0 = mul(ma0, mb0);
  assign pp2_0 = prod0 & PMASK;
  assign pp1_0 = prod0 - pp2_0;

  mult_sched #(.NREQ(N), .MREG(1)) u1 (
    .CLK(CLK), .RSTN(RSTN),
    .REQ_VALID(req_valid), .REQ_READY(rdy1),
    .REQ_A(req_a), .REQ_B(req_b),
    .MULT_A(ma1), .MULT_B(mb1),
    .MULT_CEM(cem1), .MULT_RSTM(rstm1),
    .MULT_PP1(pp1_1), .MULT_PP2(pp2_1),
    .RES_VALID(rv1), .RES_READY(res_ready),
    .RES_P(p1), .RES_ID(id1)
`ifdef MULT_SCHED_STATS_EN
    , .STAT_ISSUE(si1), .STAT_STALL(ss1)
`endif
  );

  mult_sched #(.NREQ(N), .MREG(0)) u0 (
    .CLK(CLK), .RSTN(RSTN),
    .REQ_VALID(req_valid), .REQ_READY(rdy0),
    .REQ_A(req_a), .REQ_B(req_b),
    .MULT_A(ma0), .MULT_B(mb0),
    .MULT_CEM(cem0), .MULT_RSTM(rstm0),
    .MULT_PP1(pp1_0), .MULT_PP2(pp2_0),
    .RES_VALID(rv0), .RES_READY(res_ready),
    .RES_P(p0), .RES_ID(id0)
`ifdef MULT_SCHED_STATS_EN
    , .STAT_ISSUE(si0), .STAT_STALL(ss0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic op(input int i, input longint a, input longint b);
    req_a[i*25 +: 25] = 25'(a);
    req_b[i*18 +: 18] = 18'(b);
  endtask

  task automatic load_table();
    op(0, 7, 3);
    op(1, -11, 5);
    op(2, 13, -2);
    op(3, 1000, -1000);
  endtask

  initial begin
    RSTN = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    tick();
    req_valid = 4'hF;
    tick();
    settle();
    chk("rst_ready1", rdy1, 0);
    chk("rst_ready0", rdy0, 0);
    chk("rst_ma", ma1, 0);
    chk("rst_mb", mb1, 0);
    chk("rst_cem", cem1, 0);
    chk("rst_rstm", rstm1, 1);
    chk("rst_rv", rv1, 0);
    chk("rst_p", p1, 0);
    chk("rst_id", id1, 0);

    req_valid = '0;
    RSTN = 1'b1;
    settle();
    chk("rstm_hold", rstm1, 1);
    tick();
    chk("rstm_clear", rstm1, 0);

    // single request from requester 2
    req_valid = 4'b0100;
    op(2, 100, -3);
    res_ready = 1'b1;
    settle();
    chk("one_gnt", rdy1, 4'b0100);
    chk("one_cem", cem1, 1);
    chk("one_ma", ma1, 100);
    chk("one_mb", mb1, 18'h3FFFD);
    tick();
    req_valid = '0;
    settle();
    chk("one_t1_rv", rv1, 0);
    chk("idle_cem", cem1, 0);
    chk("idle_ma", ma1, 0);
    tick();
    settle();
    chk("one_t2_rv", rv1, 1);
    chk("one_p", p1, p43(-300));
    chk("one_id", id1, 2);
    tick();
    settle();
    chk("one_pop", rv1, 0);

    // corner operands; ptr sits at 3 so requester 0 wins first
    req_valid = 4'b0011;
    op(0, -(64'sd1 <<< 24), -(64'sd1 <<< 17));
    op(1, (64'sd1 <<< 24) - 1, (64'sd1 <<< 17) - 1);
    settle();
    chk("cor_gnt0", rdy1, 4'b0001);
    tick();
    req_valid = 4'b0010;
    settle();
    chk("cor_gnt1", rdy1, 4'b0010);
    tick();
    req_valid = '0;
    settle();
    chk("cor_rv", rv1, 1);
    chk("cor_p_min", p1, p43(64'sd2199023255552));
    chk("cor_id0", id1, 0);
    tick();
    settle();
    chk("cor_p_max", p1, p43(64'sd2199006347265));
    chk("cor_id1", id1, 1);
    tick();
    settle();
    chk("cor_empty", rv1, 0);

    // contention: all valid, ptr starts at 2
    load_table();
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("rr_gnt", rdy1, 64'd1 << ((2 + c) % 4));
      if (c >= 2) begin
        chk("rr_rv", rv1, 1);
        chk("rr_id", id1, c % 4);
        chk("rr_p", p1, p43(cp[c % 4]));
      end
      tick();
    end
    req_valid = '0;
    settle();
    chk("drain_id0", id1, 0);
    chk("drain_p0", p1, p43(cp[0]));
    tick();
    settle();
    chk("drain_id1", id1, 1);
    chk("drain_p1", p1, p43(cp[1]));
    tick();
    settle();
    chk("drain_empty", rv1, 0);

    // backpressure: two issues, then no grants until a pop
    res_ready = 1'b0;
    req_valid = 4'hF;
    settle();
    chk("bp_g0", rdy1, 4'b0100);
    tick();
    settle();
    chk("bp_g1", rdy1, 4'b1000);
    tick();
    settle();
    chk("bp_full0", rdy1, 0);
    tick();
    settle();
    chk("bp_full1", rdy1, 0);
    chk("bp_rv", rv1, 1);
    chk("bp_id", id1, 2);
    chk("bp_p", p1, p43(cp[2]));
    tick();
    settle();
    chk("bp_full2", rdy1, 0);
    chk("bp_stable", id1, 2);
    res_ready = 1'b1;
    settle();
    chk("bp_resume", rdy1, 4'b0001);
    tick();
    settle();
    chk("bp_id3", id1, 3);
    chk("bp_p3", p1, p43(cp[3]));
    chk("bp_g2", rdy1, 4'b0010);
    req_valid = '0;
    tick();
    settle();
    chk("bp_id_r0", id1, 0);
    chk("bp_p_r0", p1, p43(cp[0]));
    tick();
    settle();
    chk("bp_empty", rv1, 0);

    // reset with one buffered and one in flight; ptr is 1
    res_ready = 1'b0;
    req_valid = 4'b0011;
    settle();
    chk("mr_g1", rdy1, 4'b0010);
    tick();
    settle();
    chk("mr_g0", rdy1, 4'b0001);
    tick();
    settle();
    chk("mr_buffered", rv1, 1);
    RSTN = 1'b0;
    settle();
    chk("mr_rv", rv1, 0);
    chk("mr_ready", rdy1, 0);
    chk("mr_cem", cem1, 0);
    chk("mr_ma", ma1, 0);
    chk("mr_mb", mb1, 0);
    chk("mr_p", p1, 0);
    chk("mr_id", id1, 0);
    chk("mr_rstm", rstm1, 1);
    tick();
    RSTN = 1'b1;
    req_valid = '0;
    settle();
    chk("mr_rstm_hold", rstm1, 1);
    chk("mr_rv_rel", rv1, 0);
    tick();
    settle();
    chk("mr_rstm_clr", rstm1, 0);
    for (int k = 0; k < 3; k++) begin
      chk("mr_no_stale", rv1, 0);
      tick();
      settle();
    end

    // MREG=0 instance: result one cycle after issue
    res_ready = 1'b1;
    load_table();
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("m0_gnt", rdy0, 64'd1 << k);
      if (k >= 1) begin
        chk("m0_rv", rv0, 1);
        chk("m0_id", id0, k - 1);
        chk("m0_p", p0, p43(cp[k - 1]));
      end
      tick();
    end
    req_valid = '0;
    settle();
    chk("m0_id3", id0, 3);
    chk("m0_p3", p0, p43(cp[3]));
    tick();
    settle();
    chk("m0_empty", rv0, 0);
`ifdef MULT_SCHED_STATS_EN
    chk("stat_issue0", si0, 4);
    chk("stat_issue1", si1, 4);
    chk("stat_stall0", ss0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
